// File: rtl/pwm_audio_out_mc.sv
// Multi-channel PWM audio DAC with complementary, dead-time separated outputs and a one-frame hold buffer.
// Optional NOISE_SHAPE_EN macro adds per-channel error feedback of the truncated sample LSBs.
module pwm_audio_out_mc #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 16,
  parameter int PWM_BITS = 8,
  parameter int DEADTIME = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
  output logic [CHANNELS-1:0]          pwm_out_p,
  output logic [CHANNELS-1:0]          pwm_out_n,
  output logic                         frame_tick,
  output logic                         underrun
);

  localparam int ERR_W  = SAMPLE_W - PWM_BITS;
  localparam int STAB_W = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [STAB_W-1:0]   STAB_MAX = STAB_W'(DEADTIME);
  localparam logic [PWM_BITS-1:0] MIDSCALE = PWM_BITS'(1) << (PWM_BITS - 1);

  logic [PWM_BITS-1:0]          cnt;
  logic                         pending;
  logic [CHANNELS*SAMPLE_W-1:0] hold;
  logic                         boundary;
  logic                         load;

  assign boundary   = (cnt == '1);
  assign load       = boundary && pending;
  assign s_ready    = !pending;
  assign frame_tick = boundary;
  assign underrun   = boundary && !pending;

  // A frame accepted in the boundary cycle only fills hold; it is loaded one period later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      pending <= 1'b0;
      hold    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (load) begin
        pending <= 1'b0;
      end else if (s_valid && s_ready) begin
        hold    <= s_data;
        pending <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] offset;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_next;
    logic                raw;
    logic                raw_next;
    logic [STAB_W-1:0]   stable;

    assign sample = hold[k*SAMPLE_W +: SAMPLE_W];
    assign offset = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};

`ifdef NOISE_SHAPE_EN
    logic [ERR_W-1:0]  err;
    logic [SAMPLE_W:0] sum;

    // Carry-out means the rounded value exceeded full scale, so clamp the duty.
    assign sum       = {1'b0, offset} + {{(PWM_BITS + 1){1'b0}}, err};
    assign duty_next = sum[SAMPLE_W] ? '1 : sum[SAMPLE_W-1 -: PWM_BITS];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        err <= '0;
      end else if (load) begin
        err <= sum[ERR_W-1:0];
      end
    end
`else
    logic unused_lsbs;

    assign unused_lsbs = ^offset[ERR_W-1:0];
    assign duty_next   = offset[SAMPLE_W-1 -: PWM_BITS];
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        duty <= MIDSCALE;
      end else if (load) begin
        duty <= duty_next;
      end
    end

    assign raw_next = (cnt < duty);

    // stable counts cycles since raw last toggled; a leg may only drive once it saturates.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        raw    <= 1'b0;
        stable <= '0;
      end else begin
        raw <= raw_next;
        if (raw_next != raw) begin
          stable <= '0;
        end else if (stable < STAB_MAX) begin
          stable <= stable + 1'b1;
        end
      end
    end

    assign pwm_out_p[k] = raw && (stable >= STAB_MAX);
    assign pwm_out_n[k] = !raw && (stable >= STAB_MAX);
  end

endmodule

// File: tb/tb_pwm_audio_out_mc.sv
// Directed self-checking bench for pwm_audio_out_mc (2 channels, 8-bit PWM, dead-time 2).
// The noise-shaping scenario is compiled only when NOISE_SHAPE_EN is defined.
module tb_pwm_audio_out_mc;

  localparam int CH = 2;
  localparam int SW = 16;
  localparam int PB = 8;
  localparam int DT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [CH*SW-1:0] s_data = '0;
  logic [CH-1:0]    pwm_out_p;
  logic [CH-1:0]    pwm_out_n;
  logic             frame_tick;
  logic             underrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_audio_out_mc #(
    .CHANNELS(CH),
    .SAMPLE_W(SW),
    .PWM_BITS(PB),
    .DEADTIME(DT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .pwm_out_p(pwm_out_p),
    .pwm_out_n(pwm_out_n),
    .frame_tick(frame_tick),
    .underrun(underrun)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts leg activity over 256 cycles starting the cycle after a boundary.
  task automatic measure_period(output int p0, output int p1, output int n0, output int n1,
                                output int overlap, output int ticks, output int unders,
                                output int lone);
    p0 = 0; p1 = 0; n0 = 0; n1 = 0; overlap = 0; ticks = 0; unders = 0; lone = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (pwm_out_p[0]) p0++;
      if (pwm_out_p[1]) p1++;
      if (pwm_out_n[0]) n0++;
      if (pwm_out_n[1]) n1++;
      if ((pwm_out_p & pwm_out_n) != '0) overlap++;
      if (frame_tick) ticks++;
      if (underrun) unders++;
      if (underrun && !frame_tick) lone++;
    end
  endtask

  task automatic sync_boundary(output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!frame_tick && waited < 300);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pwm_out_p !== 2'b00) begin errors++; $display("[TB] FAIL reset_p: got %b expected 00", pwm_out_p); end
    checks++; if (pwm_out_n !== 2'b00) begin errors++; $display("[TB] FAIL reset_n: got %b expected 00", pwm_out_n); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", s_ready); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: got %b expected 0", frame_tick); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_midscale();
    int waited, first_p;
    int p0, p1, n0, n1, ov, tk, un, lone;
    rst = 1'b1;
    waited = 0;
    first_p = -1;
    do begin
      step();
      waited++;
      if (first_p < 0 && pwm_out_p[0]) first_p = waited;
    end while (!frame_tick && waited < 300);
    checks++; if (waited != 255) begin errors++; $display("[TB] FAIL first_boundary: got %0d expected 255", waited); end
    checks++; if (first_p != 3) begin errors++; $display("[TB] FAIL first_p_edge: got %0d expected 3", first_p); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL idle_underrun: got %b expected 1", underrun); end
    measure_period(p0, p1, n0, n1, ov, tk, un, lone);
    checks++; if (p0 != 126) begin errors++; $display("[TB] FAIL mid_p0: got %0d expected 126", p0); end
    checks++; if (p1 != 126) begin errors++; $display("[TB] FAIL mid_p1: got %0d expected 126", p1); end
    checks++; if (n0 != 126) begin errors++; $display("[TB] FAIL mid_n0: got %0d expected 126", n0); end
    checks++; if (n1 != 126) begin errors++; $display("[TB] FAIL mid_n1: got %0d expected 126", n1); end
    checks++; if (un != 1 || tk != 1) begin errors++; $display("[TB] FAIL mid_pulses: got underrun %0d tick %0d expected 1 1", un, tk); end
  endtask

  task automatic test_extremes();
    int waited;
    int p0, p1, n0, n1, ov, tk, un, lone;
    step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL ext_ready_before: got %b expected 1", s_ready); end
    s_valid = 1'b1;
    s_data = {16'h7FFF, 16'h8000};
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL ext_ready_after: got %b expected 0", s_ready); end
    sync_boundary(waited);
    checks++; if (waited != 254 || underrun !== 1'b0) begin errors++; $display("[TB] FAIL ext_load_boundary: got wait %0d underrun %b expected 254 0", waited, underrun); end
    measure_period(p0, p1, n0, n1, ov, tk, un, lone);
    measure_period(p0, p1, n0, n1, ov, tk, un, lone);
    checks++; if (p0 != 0) begin errors++; $display("[TB] FAIL ext_p0: got %0d expected 0", p0); end
    checks++; if (n0 != 256) begin errors++; $display("[TB] FAIL ext_n0: got %0d expected 256", n0); end
    checks++; if (p1 != 253) begin errors++; $display("[TB] FAIL ext_p1: got %0d expected 253", p1); end
    checks++; if (n1 != 0) begin errors++; $display("[TB] FAIL ext_n1: got %0d expected 0", n1); end
    checks++; if (ov != 0) begin errors++; $display("[TB] FAIL ext_overlap: got %0d expected 0", ov); end
    checks++; if (un != 1) begin errors++; $display("[TB] FAIL ext_underrun: got %0d expected 1", un); end
  endtask

  // Frame A is offered in a boundary cycle, so it only loads at the following boundary.
  task automatic test_back_to_back();
    int ready_low, p0a, p1a, p0b, p1b;
    logic tick_end1, under_end1, ready_now, under_end2;
    ready_low = 0; p0a = 0; p1a = 0; p0b = 0; p1b = 0;
    s_valid = 1'b1;
    s_data = {16'hC000, 16'h2000};
    @(posedge clk);
    #1 s_data = {16'h4000, 16'h4000};
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      if (!s_ready) ready_low++;
      if (pwm_out_p[0]) p0a++;
      if (pwm_out_p[1]) p1a++;
    end
    tick_end1 = frame_tick;
    under_end1 = underrun;
    step();
    ready_now = s_ready;
    if (pwm_out_p[0]) p0b++;
    if (pwm_out_p[1]) p1b++;
    @(posedge clk);
    #1 s_valid = 1'b0;
    for (int i = 1; i < 256; i++) begin
      if (i > 1) @(posedge clk);
      @(negedge clk);
      if (pwm_out_p[0]) p0b++;
      if (pwm_out_p[1]) p1b++;
    end
    under_end2 = underrun;
    checks++; if (ready_low != 256) begin errors++; $display("[TB] FAIL b2b_ready_low: got %0d expected 256", ready_low); end
    checks++; if (p0a != 0 || p1a != 253) begin errors++; $display("[TB] FAIL b2b_no_early_load: got p0 %0d p1 %0d expected 0 253", p0a, p1a); end
    checks++; if (tick_end1 !== 1'b1 || under_end1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_boundary1: got tick %b underrun %b expected 1 0", tick_end1, under_end1); end
    checks++; if (ready_now !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_reopen: got %b expected 1", ready_now); end
    checks++; if (p0b != 158 || p1b != 62) begin errors++; $display("[TB] FAIL b2b_frame_a: got p0 %0d p1 %0d expected 158 62", p0b, p1b); end
    checks++; if (under_end2 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_boundary2: got underrun %b expected 0", under_end2); end
  endtask

  task automatic test_starve();
    int p0, p1, n0, n1, ov, tk, un, lone;
    measure_period(p0, p1, n0, n1, ov, tk, un, lone);
    measure_period(p0, p1, n0, n1, ov, tk, un, lone);
    checks++; if (p0 != 190 || p1 != 190) begin errors++; $display("[TB] FAIL starve_p: got %0d %0d expected 190 190", p0, p1); end
    checks++; if (n0 != 62 || n1 != 62) begin errors++; $display("[TB] FAIL starve_n: got %0d %0d expected 62 62", n0, n1); end
    checks++; if (un != 1 || tk != 1 || lone != 0) begin errors++; $display("[TB] FAIL starve_pulses: got underrun %0d tick %0d lone %0d expected 1 1 0", un, tk, lone); end
    checks++; if (ov != 0) begin errors++; $display("[TB] FAIL starve_overlap: got %0d expected 0", ov); end
  endtask

  task automatic test_mid_reset();
    int waited;
    int p0, p1, n0, n1, ov, tk, un, lone;
    repeat (100) step();
    checks++; if (pwm_out_p[0] !== 1'b1) begin errors++; $display("[TB] FAIL mrst_pre_p: got %b expected 1", pwm_out_p[0]); end
    s_valid = 1'b1;
    s_data = {16'h8000, 16'h8000};
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL mrst_pending: got ready %b expected 0", s_ready); end
    #2 rst = 1'b0;
    #1;
    checks++; if (pwm_out_p !== 2'b00 || pwm_out_n !== 2'b00) begin errors++; $display("[TB] FAIL mrst_outputs: got p %b n %b expected 00 00", pwm_out_p, pwm_out_n); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL mrst_ready: got %b expected 1", s_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sync_boundary(waited);
    checks++; if (waited != 255 || underrun !== 1'b1) begin errors++; $display("[TB] FAIL mrst_boundary: got wait %0d underrun %b expected 255 1", waited, underrun); end
    measure_period(p0, p1, n0, n1, ov, tk, un, lone);
    checks++; if (p0 != 126 || p1 != 126) begin errors++; $display("[TB] FAIL mrst_midscale: got %0d %0d expected 126 126", p0, p1); end
  endtask

`ifdef NOISE_SHAPE_EN
  task automatic test_noise_shape();
    int pc[6];
    int p0, p1, n0, n1, ov, tk, un, lone, ov_total;
    ov_total = 0;
    s_valid = 1'b1;
    s_data = {16'h0080, 16'h0080};
    for (int k = 0; k < 6; k++) begin
      measure_period(p0, p1, n0, n1, ov, tk, un, lone);
      pc[k] = p0;
      ov_total += ov;
    end
    s_valid = 1'b0;
    for (int k = 3; k < 6; k++) begin
      checks++; if (pc[k] + pc[k-1] != 253) begin errors++; $display("[TB] FAIL ns_alternate: got %0d+%0d expected sum 253", pc[k-1], pc[k]); end
    end
    checks++; if (ov_total != 0) begin errors++; $display("[TB] FAIL ns_overlap: got %0d expected 0", ov_total); end
  endtask
`endif

  initial begin
    test_reset();
    test_midscale();
    test_extremes();
    test_back_to_back();
    test_starve();
    test_mid_reset();
`ifdef NOISE_SHAPE_EN
    test_noise_shape();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
